// File: rtl/sample_fifo.sv
// Synchronous sample FIFO with registered read port, occupancy flags and sticky error flags.
// Optional zero-sample interpolation is enabled by defining SAMPLE_INTERP_EN.
module sample_fifo #(
  parameter int DATA_WIDTH    = 64,
  parameter int ADDR_WIDTH    = 3,
  parameter int AFULL_THRESH  = (2 ** ADDR_WIDTH) - 2,
  parameter int AEMPTY_THRESH = 2
) (
  input  logic                  sclk,
  input  logic                  reset,
  input  logic                  write_en,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic                  read_en,
  input  logic                  clear_flags,
  output logic [DATA_WIDTH-1:0] read_data,
  output logic                  read_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0]   CNT_ONE    = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH:0]   CNT_FULL   = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0]   AFULL_LVL  = AFULL_THRESH[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0]   AEMPTY_LVL = AEMPTY_THRESH[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE    = CNT_ONE[ADDR_WIDTH-1:0];

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr_r;
  logic [ADDR_WIDTH-1:0] rd_ptr_r;
  logic [ADDR_WIDTH:0]   count_r;
  logic [ADDR_WIDTH:0]   count_next_s;
  logic [DATA_WIDTH-1:0] read_data_r;
  logic                  read_valid_r;
  logic                  overflow_r;
  logic                  underflow_r;
  logic                  full_s;
  logic                  empty_s;
  logic                  wr_acc_s;
  logic                  rd_acc_s;
  logic [DATA_WIDTH-1:0] store_data_s;

`ifdef SAMPLE_INTERP_EN
  logic [DATA_WIDTH-1:0] h1_r;
  logic [DATA_WIDTH-1:0] h2_r;
  logic [DATA_WIDTH:0]   interp_sum_s;
`endif

  // Occupancy flags decode straight from the count register.
  always_comb begin
    full_s       = (count_r == CNT_FULL);
    empty_s      = (count_r == {(ADDR_WIDTH+1){1'b0}});
    almost_full  = (count_r >= AFULL_LVL);
    almost_empty = (count_r <= AEMPTY_LVL);
  end

  // Accept decisions, next count and the value that will actually be stored.
  always_comb begin
    wr_acc_s = write_en & ~full_s & ~reset;
    rd_acc_s = read_en & ~empty_s & ~reset;
    case ({wr_acc_s, rd_acc_s})
      2'b10:   count_next_s = count_r + CNT_ONE;
      2'b01:   count_next_s = count_r - CNT_ONE;
      default: count_next_s = count_r;
    endcase
`ifdef SAMPLE_INTERP_EN
    // Sum is one bit wider so two maximal samples average without loss.
    interp_sum_s = {1'b0, h1_r} + {1'b0, h2_r};
    if (write_data == {DATA_WIDTH{1'b0}}) begin
      store_data_s = DATA_WIDTH'(interp_sum_s >> 1);
    end else begin
      store_data_s = write_data;
    end
`else
    store_data_s = write_data;
`endif
  end

  // Storage array; contents are deliberately left uninitialised on reset.
  always_ff @(posedge sclk) begin
    if (wr_acc_s) begin
      mem[wr_ptr_r] <= store_data_s;
    end
  end

  // Pointers, occupancy, read port and sticky error flags.
  always_ff @(posedge sclk or posedge reset) begin
    if (reset) begin
      wr_ptr_r     <= {ADDR_WIDTH{1'b0}};
      rd_ptr_r     <= {ADDR_WIDTH{1'b0}};
      count_r      <= {(ADDR_WIDTH+1){1'b0}};
      read_data_r  <= {DATA_WIDTH{1'b0}};
      read_valid_r <= 1'b0;
      overflow_r   <= 1'b0;
      underflow_r  <= 1'b0;
    end else begin
      count_r      <= count_next_s;
      read_valid_r <= rd_acc_s;
      if (wr_acc_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (rd_acc_s) begin
        read_data_r <= mem[rd_ptr_r];
        rd_ptr_r    <= rd_ptr_r + PTR_ONE;
      end
      // A new error in the same cycle as a clear keeps the flag set.
      if (write_en && full_s) begin
        overflow_r <= 1'b1;
      end else if (clear_flags) begin
        overflow_r <= 1'b0;
      end
      if (read_en && empty_s) begin
        underflow_r <= 1'b1;
      end else if (clear_flags) begin
        underflow_r <= 1'b0;
      end
    end
  end

`ifdef SAMPLE_INTERP_EN
  // History of the last two values actually stored.
  always_ff @(posedge sclk or posedge reset) begin
    if (reset) begin
      h1_r <= {DATA_WIDTH{1'b0}};
      h2_r <= {DATA_WIDTH{1'b0}};
    end else if (wr_acc_s) begin
      h1_r <= store_data_s;
      h2_r <= h1_r;
    end
  end
`endif

  assign count      = count_r;
  assign full       = full_s;
  assign empty      = empty_s;
  assign read_data  = read_data_r;
  assign read_valid = read_valid_r;
  assign overflow   = overflow_r;
  assign underflow  = underflow_r;

endmodule

// File: tb/tb_sample_fifo.sv
// Scoreboard bench for sample_fifo: queue-based reference model, directed corner cases and random traffic.
module tb_sample_fifo;

  localparam int DW    = 64;
  localparam int AW    = 3;
  localparam int DEPTH = 8;

  logic          sclk = 1'b0;
  logic          reset;
  logic          write_en;
  logic [DW-1:0] write_data;
  logic          read_en;
  logic          clear_flags;
  logic [DW-1:0] read_data;
  logic          read_valid;
  logic          full, empty, almost_full, almost_empty;
  logic [AW:0]   count;
  logic          overflow, underflow;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model state
  logic [DW-1:0] mq[$];
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] h1 = '0, h2 = '0, last_rd = '0;
  bit            m_ov = 0, m_un = 0, m_rv = 0;

  sample_fifo dut (
    .sclk(sclk), .reset(reset), .write_en(write_en), .write_data(write_data),
    .read_en(read_en), .clear_flags(clear_flags), .read_data(read_data),
    .read_valid(read_valid), .full(full), .empty(empty), .almost_full(almost_full),
    .almost_empty(almost_empty), .count(count), .overflow(overflow), .underflow(underflow)
  );

  always #5 sclk = ~sclk;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_state();
    int sz;
    sz = mq.size();
    check("count",        DW'(count),        DW'(sz));
    check("full",         DW'(full),         DW'(sz == DEPTH));
    check("empty",        DW'(empty),        DW'(sz == 0));
    check("almost_full",  DW'(almost_full),  DW'(sz >= DEPTH - 2));
    check("almost_empty", DW'(almost_empty), DW'(sz <= 2));
    check("overflow",     DW'(overflow),     DW'(m_ov));
    check("underflow",    DW'(underflow),    DW'(m_un));
    check("read_valid",   DW'(read_valid),   DW'(m_rv));
    check("read_data",    read_data,         last_rd);
  endtask

  task automatic model_clear();
    mq.delete();
    exp_q.delete();
    h1 = '0; h2 = '0; last_rd = '0;
    m_ov = 0; m_un = 0; m_rv = 0;
  endtask

  // One clock cycle of stimulus; called at a falling edge.
  task automatic step(input bit we, input logic [DW-1:0] wd, input bit re, input bit cf);
    bit            is_full, is_empty, wacc, racc;
    logic [DW:0]   sum;
    logic [DW-1:0] val;
    is_full  = (mq.size() == DEPTH);
    is_empty = (mq.size() == 0);
    wacc = we && !is_full;
    racc = re && !is_empty;
    if (we && is_full) m_ov = 1; else if (cf) m_ov = 0;
    if (re && is_empty) m_un = 1; else if (cf) m_un = 0;
    m_rv = racc;
    if (racc) begin
      last_rd = mq.pop_front();
      exp_q.push_back(last_rd);
    end
    if (wacc) begin
      val = wd;
`ifdef SAMPLE_INTERP_EN
      if (wd == '0) begin
        sum = {1'b0, h1} + {1'b0, h2};
        val = sum[DW:1];
      end
      h2 = h1;
      h1 = val;
`endif
      mq.push_back(val);
    end
    sum = '0;
    write_en = we; write_data = wd; read_en = re; clear_flags = cf;
    @(posedge sclk);
    #1;
    check_state();
    @(negedge sclk);
    write_en = 1'b0; read_en = 1'b0; clear_flags = 1'b0;
  endtask

  // Asynchronous reset in the middle of a cycle, with a write pending.
  task automatic mid_reset();
    write_en = 1'b1; write_data = 64'd55;
    #1 reset = 1'b1;
    #1;
    model_clear();
    check("rst_count",      DW'(count),      '0);
    check("rst_empty",      DW'(empty),      64'd1);
    check("rst_read_valid", DW'(read_valid), '0);
    @(posedge sclk);
    #1 check("rst_no_write", DW'(count), '0);
    @(negedge sclk);
    reset = 1'b0; write_en = 1'b0;
    #1 check_state();
  endtask

  // Scoreboard monitor: every presented sample must match the next expected one.
  initial begin
    forever begin
      @(posedge sclk);
      #2;
      if (read_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL scoreboard_unexpected: got %0h expected no sample", read_data);
        end else begin
          check("scoreboard_data", read_data, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    logic [DW-1:0] d;
    int            r;
    reset = 1'b1; write_en = 1'b0; write_data = '0; read_en = 1'b0; clear_flags = 1'b0;
    repeat (2) @(negedge sclk);
    check_state();
    reset = 1'b0;

    // fill 1..8, then overflow
    for (int i = 1; i <= DEPTH; i++) step(1, DW'(i), 0, 0);
    step(1, 64'd9, 0, 0);
    // clear loses to a simultaneous overflow, then clears alone
    step(1, 64'd10, 0, 1);
    step(0, '0, 0, 1);
    // drain in order, then underflow
    for (int i = 0; i < DEPTH; i++) step(0, '0, 1, 0);
    step(0, '0, 1, 0);
    step(0, '0, 0, 1);

    // simultaneous read/write on full and on empty
    for (int i = 0; i < DEPTH; i++) step(1, DW'(100 + i), 0, 0);
    step(1, 64'd99, 1, 0);
    for (int i = 0; i < DEPTH; i++) step(0, '0, 1, 0);
    step(1, 64'd99, 1, 0);
    step(0, '0, 1, 0);

    // zero-sample handling
    step(1, 64'd10, 0, 0);
    step(1, 64'd20, 0, 0);
    step(1, 64'd0, 0, 0);
    step(1, {DW{1'b1}}, 0, 0);
    step(1, {DW{1'b1}}, 0, 0);
    step(1, 64'd0, 0, 0);
    for (int i = 0; i < 6; i++) step(0, '0, 1, 0);

    // reset mid-burst
    for (int i = 0; i < 5; i++) step(1, DW'(200 + i), 0, 0);
    mid_reset();
    step(1, 64'd7, 0, 0);
    step(0, '0, 1, 0);
    step(0, '0, 0, 0);

    // random traffic with wraps, zeros and extreme values
    for (int c = 0; c < 1200; c++) begin
      r = $urandom_range(0, 3);
      if (r == 0)      d = '0;
      else if (r == 1) d = {DW{1'b1}};
      else             d = {$urandom, $urandom};
      if (c == 600) mid_reset();
      step($urandom_range(0, 99) < 55, d, $urandom_range(0, 99) < 50, $urandom_range(0, 99) < 8);
    end

    for (int i = 0; i < DEPTH + 2; i++) step(0, '0, 1, 0);
    step(0, '0, 0, 0);
    check("scoreboard_drained", DW'(exp_q.size()), '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sample_fifo.md
SAMPLE_FIFO -- requirements
Module: sample_fifo

Interface
REQ-001 Parameter DATA_WIDTH, default 64: sample width in bits.
REQ-002 Parameter ADDR_WIDTH, default 3: address width; DEPTH = 2**ADDR_WIDTH entries.
REQ-003 Parameter AFULL_THRESH, default DEPTH-2: almost_full asserts when count >= AFULL_THRESH.
REQ-004 Parameter AEMPTY_THRESH, default 2: almost_empty asserts when count <= AEMPTY_THRESH.
REQ-005 sclk  input  1  clock; all state updates on rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 write_en  input  1  write request.
REQ-008 write_data  input  DATA_WIDTH  sample to enqueue.
REQ-009 read_en  input  1  read request.
REQ-010 clear_flags  input  1  synchronous clear of sticky overflow/underflow.
REQ-011 read_data  output  DATA_WIDTH  registered dequeued sample.
REQ-012 read_valid  output  1  high for one cycle when read_data is new.
REQ-013 full, empty, almost_full, almost_empty  output  1 each  occupancy flags.
REQ-014 count  output  ADDR_WIDTH+1  current occupancy, 0..DEPTH.
REQ-015 overflow, underflow  output  1 each  sticky error flags.

Function
REQ-016 A write SHALL be accepted iff write_en=1 and full=0 at the clock edge; accepted data stored at write pointer, pointer +1 modulo DEPTH.
REQ-017 A read SHALL be accepted iff read_en=1 and empty=0; entry at read pointer loaded into read_data, pointer +1 modulo DEPTH.
REQ-018 Read latency SHALL be one cycle: read_valid=1 in the cycle after an accepted read, 0 otherwise; read_data holds its last value when no read is accepted.
REQ-019 count SHALL update +1 (write only), -1 (read only), unchanged (both or neither accepted).
REQ-020 Full with read+write: read accepted, write rejected, count becomes DEPTH-1.
REQ-021 Empty with read+write: write accepted, read rejected, read_valid stays 0, count becomes 1.
REQ-022 full, empty, almost_full, almost_empty SHALL be combinational decodes of the count register only (full: count==DEPTH; empty: count==0).
REQ-023 overflow SHALL set on write_en=1 while full=1; underflow SHALL set on read_en=1 while empty=1; both hold until cleared.
REQ-024 clear_flags=1 SHALL clear both sticky flags next edge; a set condition in the same cycle wins (flag stays 1).
REQ-025 Pointers SHALL wrap silently; no data corruption across any number of wraps.

Reset
REQ-026 reset=1 SHALL asynchronously force count=0, pointers=0, read_data=0, read_valid=0, overflow=0, underflow=0, interpolation history=0; hence empty=1, almost_empty=1, full=0, almost_full=0.
REQ-027 Reset mid-operation SHALL discard all contents; memory array need not be cleared; no read or write is accepted while reset=1.

Configuration
REQ-028 Macro SAMPLE_INTERP_EN: when defined, an accepted write with write_data==0 SHALL store (h1+h2)>>1, h1/h2 = last two stored values, sum computed in DATA_WIDTH+1 bits, no overflow loss.
REQ-029 h1/h2 SHALL be dedicated history registers updated only on accepted writes with the value actually stored; reads and rejected writes SHALL not affect them.
REQ-030 Without SAMPLE_INTERP_EN, zero samples SHALL be stored verbatim and history registers SHALL not exist.

Verification
REQ-031 Reset, write 8 samples 1..8 (DEPTH=8) -> full=1, almost_full=1, count=8; 9th write rejected, overflow=1.
REQ-032 Read 8 times from full -> read_data 1..8 in order, each with read_valid one cycle after read_en; then empty=1; 9th read -> underflow=1, read_valid=0.
REQ-033 Full queue, read_en+write_en (data 99) same cycle -> read accepted, 99 not stored, count=7; empty queue same stimulus -> count=1, read_valid=0.
REQ-034 With SAMPLE_INTERP_EN: write 10, 20, 0 -> third entry reads 15; write 2**64-1, 2**64-1, 0 -> reads 2**64-1; without macro -> third entry reads 0.
REQ-035 Write 5 entries, assert reset mid-burst -> count=0, empty=1, read_valid=0 immediately; subsequent write 7 then read -> 7.
REQ-036 overflow set, clear_flags=1 with write_en=1 while full -> overflow stays 1; clear_flags=1 alone next cycle -> overflow=0.
